// File: rtl/wb8_arb_pkg.sv
// wb8_arb_pkg: shared state encoding and constants for the two-master Wishbone arbiter
package wb8_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;
    localparam logic [7:0] ARB_ERR_DATA = 8'hFF;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/wb8_arb_watchdog.sv
// wb8_arb_watchdog: stalled-access watchdog, counts STB-without-ACK cycles and fires a terminal pulse
//   clk, rst  : clock, asynchronous active-high reset
//   idle      : arbiter has no owner (every grant change passes through idle)
//   stb, ack  : owner strobe on the shared port (before any forcing), slave ack
//   tc        : terminal count reached this cycle, access is force-terminated
//   timeout   : sticky flag, set on first terminal count, cleared only by rst
module wb8_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic stb,
    input  logic ack,
    output logic tc,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    always_comb tc = stb && !ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt <= (idle || ack || tc) ? '0 : stb ? cnt + CW'(1) : cnt;
            if (tc)
                timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/wb8_bus_arbiter2.sv
// wb8_bus_arbiter2: two-master round-robin arbiter for the 8-bit Wishbone bus, ownership held per CYC
//   CLK_I, RST_I        : clock, asynchronous active-high reset
//   Mx_CYC/STB/WE/ADR/DAT_I, Mx_DAT_O, Mx_ACK_O : master 0 / master 1 ports
//   S_CYC/STB/WE/ADR/DAT_O, S_DAT_I, S_ACK_I    : shared slave port toward the address decoder
//   O_grant             : one-hot owner (bit0 = M0, bit1 = M1), 00 when idle
//   O_timeout           : sticky watchdog flag, present only with WB8_ARB_TIMEOUT_EN
module wb8_bus_arbiter2
    import wb8_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  M0_CYC_I,
    input  logic                  M0_STB_I,
    input  logic                  M0_WE_I,
    input  logic [ADDR_WIDTH-1:0] M0_ADR_I,
    input  logic [7:0]            M0_DAT_I,
    output logic [7:0]            M0_DAT_O,
    output logic                  M0_ACK_O,
    input  logic                  M1_CYC_I,
    input  logic                  M1_STB_I,
    input  logic                  M1_WE_I,
    input  logic [ADDR_WIDTH-1:0] M1_ADR_I,
    input  logic [7:0]            M1_DAT_I,
    output logic [7:0]            M1_DAT_O,
    output logic                  M1_ACK_O,
    output logic                  S_CYC_O,
    output logic                  S_STB_O,
    output logic                  S_WE_O,
    output logic [ADDR_WIDTH-1:0] S_ADR_O,
    output logic [7:0]            S_DAT_O,
    input  logic [7:0]            S_DAT_I,
    input  logic                  S_ACK_I,
`ifdef WB8_ARB_TIMEOUT_EN
    output logic                  O_timeout,
`endif
    output logic [1:0]            O_grant
);
    arb_state_t state, state_nx;
    logic last_owner;
    logic own0, own1, own_stb, wd_tc, term;
    logic [7:0] rdata;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE)
                last_owner <= (state_nx == OWN1);
        end
    end

    // From IDLE a tie goes to the master that did not own last; owners only ever
    // release to IDLE, which enforces the idle cycle between grants.
    always_comb begin
        state_nx = (state == OWN0) ? (M0_CYC_I ? OWN0 : IDLE)
                 : (state == OWN1) ? (M1_CYC_I ? OWN1 : IDLE)
                 : (M0_CYC_I && (!M1_CYC_I || last_owner)) ? OWN0
                 : M1_CYC_I ? OWN1 : IDLE;
    end

    // STB is qualified by CYC so an owner abandoning an access drops the strobe at once.
    always_comb begin
        own0     = (state == OWN0);
        own1     = (state == OWN1);
        O_grant  = {own1, own0};
        own_stb  = own0 ? (M0_STB_I && M0_CYC_I) : own1 ? (M1_STB_I && M1_CYC_I) : 1'b0;
        S_CYC_O  = own0 ? M0_CYC_I : own1 ? M1_CYC_I : 1'b0;
        S_STB_O  = own_stb && !wd_tc;
        S_WE_O   = own0 ? M0_WE_I : own1 ? M1_WE_I : 1'b0;
        S_ADR_O  = own0 ? M0_ADR_I : own1 ? M1_ADR_I : '0;
        S_DAT_O  = own0 ? M0_DAT_I : own1 ? M1_DAT_I : 8'h00;
        term     = S_ACK_I || wd_tc;
        rdata    = wd_tc ? ARB_ERR_DATA : S_DAT_I;
        M0_ACK_O = own0 && term;
        M1_ACK_O = own1 && term;
        M0_DAT_O = own0 ? rdata : 8'h00;
        M1_DAT_O = own1 ? rdata : 8'h00;
    end

`ifdef WB8_ARB_TIMEOUT_EN
    wb8_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK_I),
        .rst    (RST_I),
        .idle   (state == IDLE),
        .stb    (own_stb),
        .ack    (S_ACK_I),
        .tc     (wd_tc),
        .timeout(O_timeout)
    );
`else
    assign wd_tc = 1'b0;
`endif
endmodule

// File: tb/tb_wb8_bus_arbiter2.sv
// tb_wb8_bus_arbiter2: directed self-checking bench for wb8_bus_arbiter2
module tb_wb8_bus_arbiter2;
    logic        clk = 1'b0;
    logic        RST_I;
    logic        M0_CYC_I, M0_STB_I, M0_WE_I, M1_CYC_I, M1_STB_I, M1_WE_I;
    logic [31:0] M0_ADR_I, M1_ADR_I, S_ADR_O;
    logic [7:0]  M0_DAT_I, M1_DAT_I, M0_DAT_O, M1_DAT_O, S_DAT_O, S_DAT_I;
    logic        M0_ACK_O, M1_ACK_O, S_CYC_O, S_STB_O, S_WE_O, S_ACK_I;
    logic [1:0]  O_grant;
`ifdef WB8_ARB_TIMEOUT_EN
    logic        O_timeout;
`endif
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb8_bus_arbiter2 #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .CLK_I(clk), .RST_I(RST_I),
        .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
        .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O),
        .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
        .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O),
        .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O), .S_WE_O(S_WE_O), .S_ADR_O(S_ADR_O),
        .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I),
`ifdef WB8_ARB_TIMEOUT_EN
        .O_timeout(O_timeout),
`endif
        .O_grant(O_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] wdat [3];
        wdat = '{8'h11, 8'h22, 8'h33};
        RST_I = 1'b1;
        {M0_CYC_I, M0_STB_I, M0_WE_I, M1_CYC_I, M1_STB_I, M1_WE_I} = '0;
        M0_ADR_I = '0; M1_ADR_I = '0; M0_DAT_I = '0; M1_DAT_I = '0;
        S_ACK_I = 1'b0; S_DAT_I = 8'h00;
        #12;
        chk("rst_grant", 32'(O_grant), 32'h0);
        chk("rst_scyc", 32'(S_CYC_O), 32'h0);
        chk("rst_sstb", 32'(S_STB_O), 32'h0);
        chk("rst_sadr", S_ADR_O, 32'h0);
        chk("rst_sdat", 32'(S_DAT_O), 32'h0);
        chk("rst_m0ack", 32'(M0_ACK_O), 32'h0);
        chk("rst_m1ack", 32'(M1_ACK_O), 32'h0);
        chk("rst_m0dat", 32'(M0_DAT_O), 32'h0);
        // M0 read of 0xFFFFF000, request raised with reset release
        RST_I = 1'b0;
        M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'hFFFFF000; S_DAT_I = 8'h5A;
        #1;
        chk("t1_no_grant_before_edge", 32'(O_grant), 32'h0);
        chk("t1_m0dat_idle", 32'(M0_DAT_O), 32'h0);
        tick;
        chk("t1_grant", 32'(O_grant), 32'h1);
        chk("t1_sadr", S_ADR_O, 32'hFFFFF000);
        chk("t1_sstb", 32'(S_STB_O), 32'h1);
        chk("t1_m0ack_early", 32'(M0_ACK_O), 32'h0);
        tick;
        S_ACK_I = 1'b1;
        #1;
        chk("t1_m0ack", 32'(M0_ACK_O), 32'h1);
        chk("t1_m0dat", 32'(M0_DAT_O), 32'h5A);
        chk("t1_m1ack", 32'(M1_ACK_O), 32'h0);
        chk("t1_m1dat", 32'(M1_DAT_O), 32'h0);
        tick;
        S_ACK_I = 1'b0; M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
        #1;
        chk("t1_m0ack_after", 32'(M0_ACK_O), 32'h0);
        chk("t1_scyc_drop", 32'(S_CYC_O), 32'h0);
        tick;
        chk("t1_idle", 32'(O_grant), 32'h0);
        // simultaneous requests from reset
        RST_I = 1'b1; #2; RST_I = 1'b0; #1;
        M0_CYC_I = 1'b1; M1_CYC_I = 1'b1;
        tick;
        chk("t2_first_m0", 32'(O_grant), 32'h1);
        M0_CYC_I = 1'b0;
        #1;
        chk("t2_scyc_drop", 32'(S_CYC_O), 32'h0);
        tick;
        chk("t2_gap_idle", 32'(O_grant), 32'h0);
        tick;
        chk("t2_then_m1", 32'(O_grant), 32'h2);
        M1_CYC_I = 1'b0;
        tick;
        chk("t2_idle2", 32'(O_grant), 32'h0);
        M0_CYC_I = 1'b1; M1_CYC_I = 1'b1;
        tick;
        chk("t2_alternate_m0", 32'(O_grant), 32'h1);
        M0_CYC_I = 1'b0;
        tick;
        chk("t2_idle3", 32'(O_grant), 32'h0);
        tick;
        chk("t2_m1_again", 32'(O_grant), 32'h2);
        // M1 holds CYC over three writes while M0 waits
        M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h100;
        for (int i = 0; i < 3; i++) begin
            M1_STB_I = 1'b1; M1_WE_I = 1'b1; M1_ADR_I = 32'h200 + 32'(i); M1_DAT_I = wdat[i];
            #1;
            chk("t3_sdat", 32'(S_DAT_O), 32'(wdat[i]));
            chk("t3_sadr", S_ADR_O, 32'h200 + 32'(i));
            chk("t3_swe", 32'(S_WE_O), 32'h1);
            S_ACK_I = 1'b1;
            #1;
            chk("t3_m1ack", 32'(M1_ACK_O), 32'h1);
            chk("t3_m0ack", 32'(M0_ACK_O), 32'h0);
            chk("t3_grant_m1", 32'(O_grant), 32'h2);
            tick;
            S_ACK_I = 1'b0;
        end
        M1_CYC_I = 1'b0; M1_STB_I = 1'b0; M1_WE_I = 1'b0;
        tick;
        chk("t3_idle", 32'(O_grant), 32'h0);
        tick;
        chk("t3_m0_granted", 32'(O_grant), 32'h1);
        chk("t3_sadr_m0", S_ADR_O, 32'h100);
        chk("t3_swe_m0", 32'(S_WE_O), 32'h0);
        M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
        tick;
        // reset while M1 owns with STB pending
        M1_CYC_I = 1'b1; M1_STB_I = 1'b1;
        tick;
        chk("t4_grant_m1", 32'(O_grant), 32'h2);
        S_ACK_I = 1'b1;
        #1;
        chk("t4_m1ack_pre", 32'(M1_ACK_O), 32'h1);
        RST_I = 1'b1;
        #1;
        chk("t4_sstb_rst", 32'(S_STB_O), 32'h0);
        chk("t4_m1ack_rst", 32'(M1_ACK_O), 32'h0);
        chk("t4_grant_rst", 32'(O_grant), 32'h0);
        S_ACK_I = 1'b0; M0_CYC_I = 1'b1; M0_STB_I = 1'b1;
        #1;
        RST_I = 1'b0;
        #1;
        chk("t4_no_grant_release", 32'(O_grant), 32'h0);
        tick;
        chk("t4_first_m0", 32'(O_grant), 32'h1);
        {M0_CYC_I, M0_STB_I, M1_CYC_I, M1_STB_I} = '0;
        tick;
        // owner abandons an access before ack
        M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h40;
        tick;
        chk("t6_grant", 32'(O_grant), 32'h1);
        chk("t6_sstb", 32'(S_STB_O), 32'h1);
        M0_CYC_I = 1'b0;
        #1;
        chk("t6_scyc_drop", 32'(S_CYC_O), 32'h0);
        chk("t6_sstb_drop", 32'(S_STB_O), 32'h0);
        chk("t6_no_ack", 32'(M0_ACK_O), 32'h0);
        chk("t6_still_owner", 32'(O_grant), 32'h1);
        tick;
        chk("t6_idle", 32'(O_grant), 32'h0);
        chk("t6_no_ack2", 32'(M0_ACK_O), 32'h0);
        M0_STB_I = 1'b0;
        tick;
`ifdef WB8_ARB_TIMEOUT_EN
        // stalled slave, watchdog terminates on the 16th strobe cycle
        chk("t5_timeout_clear", 32'(O_timeout), 32'h0);
        M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'hDEAD0000;
        tick;
        for (int k = 1; k < 16; k++) begin
            chk("t5_no_ack_yet", 32'(M0_ACK_O), 32'h0);
            tick;
        end
        chk("t5_ack", 32'(M0_ACK_O), 32'h1);
        chk("t5_errdat", 32'(M0_DAT_O), 32'hFF);
        chk("t5_sstb_forced", 32'(S_STB_O), 32'h0);
        M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
        tick;
        chk("t5_sticky", 32'(O_timeout), 32'h1);
        chk("t5_ack_once", 32'(M0_ACK_O), 32'h0);
        M0_CYC_I = 1'b1; M0_STB_I = 1'b1; M0_ADR_I = 32'h10;
        tick;
        S_ACK_I = 1'b1; S_DAT_I = 8'h3C;
        #1;
        chk("t5_normal_ack", 32'(M0_ACK_O), 32'h1);
        chk("t5_normal_dat", 32'(M0_DAT_O), 32'h3C);
        tick;
        S_ACK_I = 1'b0; M0_CYC_I = 1'b0; M0_STB_I = 1'b0;
        #1;
        chk("t5_sticky2", 32'(O_timeout), 32'h1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
